mod_subtractor: RTL and testbench

MOD_SUBTRACTOR -- requirements
Module: mod_subtractor

---
 rtl/mod_subtractor.sv | 92 +++++++++
 tb/tb_mod_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_subtractor.sv
// mod_subtractor: 2-stage pipelined modular subtractor d = (a - b) mod Q.
// Define MOD_SUBTRACTOR_RANGE_CHECK_EN to add the range_err output.
module mod_subtractor #(
    parameter int N = 16,
    parameter int Q = 12289
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
    output logic         borrow,
    output logic         range_err
`else
    output logic         borrow
`endif
);

    localparam logic [N-1:0] QN = Q[N-1:0];

    logic         s1_valid;
    logic [N:0]   s1_raw;
    logic         s2_valid;
    logic [N-1:0] s2_d;
    logic         s2_borrow;
    logic         s2_load;
    logic         s1_load;
    logic [N-1:0] s1_fix;

    // A full S2 frees up exactly when its result leaves this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign s1_fix   = s1_raw[N] ? s1_raw[N-1:0] + QN : s1_raw[N-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_raw <= {1'b0, a} - {1'b0, b};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_d      <= '0;
            s2_borrow <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_d      <= s1_fix;
                s2_borrow <= s1_raw[N];
            end
        end
    end

    assign out_valid = s2_valid;
    assign d         = s2_d;
    assign borrow    = s2_borrow;

`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
    logic s1_err;
    logic s2_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err <= 1'b0;
            s2_err <= 1'b0;
        end else begin
            if (s1_load && in_valid) begin
                s1_err <= (a >= QN) || (b >= QN);
            end
            if (s2_load && s1_valid) begin
                s2_err <= s1_err;
            end
        end
    end

    assign range_err = s2_err;
`endif

endmodule

// File: tb/tb_mod_subtractor.sv
// tb_mod_subtractor: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based modular model.
module tb_mod_subtractor;

    localparam int N = 16;
    localparam int Q = 12289;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] d;
    logic         borrow;
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
    logic         range_err;
`endif

    mod_subtractor #(.N(N), .Q(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
        .borrow   (borrow),
        .range_err(range_err)
`else
        .borrow   (borrow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int  d;
        bit  borrow;
        bit  err;
    } exp_t;

    typedef struct {
        int  a;
        int  b;
        int  d;
        bit  borrow;
    } vec_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    logic         hold_prev = 1'b0;
    logic [N-1:0] hold_d;
    logic         hold_b;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [N-1:0] s_d;
    logic         s_borrow;
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
    logic         s_err;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int   r;
        r = x - y;
        if (r < 0) r += Q;
        e.d      = r;
        e.borrow = (x < y);
        e.err    = (x >= Q) || (y >= Q);
        return e;
    endfunction

    // One clock cycle: drive at negedge, sample 1 time unit later, score.
    task automatic step(input bit iv, input int ia, input int ib,
                        input bit ordy, input bit r);
        exp_t e;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        a         = ia[N-1:0];
        b         = ib[N-1:0];
        out_ready = ordy;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_d         = d;
        s_borrow    = borrow;
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
        s_err       = range_err;
`endif
        if (r) begin
            q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_d", int'(d), int'(hold_d));
                chk("hold_borrow", int'(borrow), int'(hold_b));
            end
            chk("in_ready", int'(in_ready),
                int'(!(q.size() == 2 && !ordy)));
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (!e.err) chk("d", int'(d), e.d);
                    if (!e.err) chk("borrow", int'(borrow), int'(e.borrow));
`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
                    chk("range_err", int'(range_err), int'(e.err));
`endif
                end
            end
            if (iv && in_ready) q.push_back(model(ia, ib));
            hold_prev = out_valid && !ordy;
            hold_d    = d;
            hold_b    = borrow;
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   k;

        vecs[0] = '{a: 5,    b: 3,     d: 2,     borrow: 1'b0};
        vecs[1] = '{a: 3,    b: 5,     d: 12287, borrow: 1'b1};
        vecs[2] = '{a: 0,    b: 12288, d: 1,     borrow: 1'b1};
        vecs[3] = '{a: 7000, b: 7000,  d: 0,     borrow: 1'b0};
        vecs[4] = '{a: 12288, b: 0,    d: 12288, borrow: 1'b0};
        vecs[5] = '{a: 0,    b: 1,     d: 12288, borrow: 1'b1};

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("rst_out_valid", int'(s_out_valid), 0);
        chk("rst_d", int'(s_d), 0);
        chk("rst_borrow", int'(s_borrow), 0);
        chk("rst_in_ready", int'(s_in_ready), 1);

        // Table vectors: accept, bubble, then result exactly two cycles on.
        foreach (vecs[i]) begin
            step(1, vecs[i].a, vecs[i].b, 1, 0);
            chk("vec_accept", int'(s_in_ready), 1);
            step(0, 0, 0, 1, 0);
            chk("vec_early", int'(s_out_valid), 0);
            step(0, 0, 0, 1, 0);
            chk("vec_valid", int'(s_out_valid), 1);
            chk("vec_d", int'(s_d), vecs[i].d);
            chk("vec_borrow", int'(s_borrow), int'(vecs[i].borrow));
        end
        step(0, 0, 0, 1, 0);
        chk("vec_idle", int'(s_out_valid), 0);

        // Backpressure: two fit, third stalls, then drain without gaps.
        step(1, 1, 0, 0, 0);
        chk("bp_acc1", int'(s_in_ready), 1);
        step(1, 2, 0, 0, 0);
        chk("bp_acc2", int'(s_in_ready), 1);
        step(1, 3, 0, 0, 0);
        chk("bp_full", int'(s_in_ready), 0);
        step(1, 3, 0, 1, 0);
        chk("bp_ready_comb", int'(s_in_ready), 1);
        chk("bp_d1", int'(s_d), 1);
        step(0, 0, 0, 1, 0);
        chk("bp_v2", int'(s_out_valid), 1);
        chk("bp_d2", int'(s_d), 2);
        step(0, 0, 0, 1, 0);
        chk("bp_v3", int'(s_out_valid), 1);
        chk("bp_d3", int'(s_d), 3);
        step(0, 0, 0, 1, 0);
        chk("bp_empty", int'(s_out_valid), 0);

        // Reset with two results in flight discards both.
        step(1, 10, 3, 0, 0);
        step(1, 20, 3, 0, 0);
        step(1, 30, 3, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("mid_rst_valid", int'(s_out_valid), 0);
        chk("mid_rst_ready", int'(s_in_ready), 1);
        chk("mid_rst_d", int'(s_d), 0);
        chk("mid_rst_borrow", int'(s_borrow), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            chk("no_stale", int'(s_out_valid), 0);
        end

`ifdef MOD_SUBTRACTOR_RANGE_CHECK_EN
        step(1, 12289, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("rc_err1", int'(s_err), 1);
        step(0, 0, 0, 1, 0);
        chk("rc_err0", int'(s_err), 0);
        chk("rc_d", int'(s_d), 1);
        step(0, 0, 0, 1, 0);
`endif

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, Q - 1)),
                 int'($urandom_range(0, Q - 1)),
                 $urandom_range(0, 2) != 0, 0);
        end

        k = 0;
        while (q.size() != 0 && k < 20) begin
            step(0, 0, 0, 1, 0);
            k++;
        end
        chk("drain_empty", q.size(), 0);
        step(0, 0, 0, 1, 0);
        chk("drain_idle", int'(s_out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
